truth_table_checker: RTL and testbench

- Synthesizable self-checking counterpart to the lab's exhaustive stimulus benches.
- Drives every input combination of an N_IN-input combinational function (boolean_function_* blocks) in binary order.
- Waits a settle interval, samples the function output and compares it with an expected truth table given as a parameter.
- Reports pass/fail, mismatch count and first failing index. It sits beside the DUT on the board or in the bench, with stim wired to the DUT inputs and dut_out wired back.

---
 rtl/truth_table_checker_pkg.sv | 21 ++
 rtl/tt_settle_timer.sv | 39 +++
 rtl/truth_table_checker.sv | 184 ++++++++++++++++++
 tb/tb_truth_table_checker.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table checker.
//   tt_state_e  : sweep controller states (idle, settling, sampling, done)
//   tt_width(n) : number of input combinations of an n-input function (2**n)
//   MAX_SETTLE  : largest supported settle interval in clock cycles
package tt_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tt_state_e;

  localparam int MAX_SETTLE = 15;

  // Number of rows in the truth table of an n-input function.
  function automatic int tt_width(input int n);
    return 32'sd1 << n;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times the settle interval after each stimulus
// change. The controller loads SETTLE-1 when the stimulus changes and enables
// counting while settling; the zero flag marks the last settle cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over en)
//   load_val   : value to load
//   en         : decrement by one when non-zero
//   zero       : counter currently holds zero
module tt_settle_timer
  import tt_check_pkg::*;
#(
  parameter int W = $clog2(MAX_SETTLE + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Settle counter register: load, count down to zero, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != '0)) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Self-checking truth-table sweeper. Drives every input combination of an
// N_IN-input combinational DUT in binary order, waits SETTLE cycles after each
// change, samples dut_out and compares it with bit [stim] of EXPECTED.
// Each combination costs SETTLE+1 cycles; a full sweep 2**N_IN*(SETTLE+1).
//
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start          : one-cycle pulse, accepted in idle or done
//   stim           : stimulus vector to the DUT inputs
//   dut_out        : DUT output under test
//   busy           : sweep in progress
//   done           : sweep finished, held until the next accepted start
//   pass           : valid while done, 1 when no mismatch was seen
//   err_count      : number of mismatching combinations (0..2**N_IN)
//   first_err_idx  : stim value of the first mismatch (valid with first_err_vld)
//   first_err_vld  : a mismatch has been recorded in this sweep
//
// Build option: define TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN to end the sweep at
// the first mismatch, leaving stim frozen at the failing index for probing.
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int                        N_IN     = 3,
  parameter logic [tt_width(N_IN)-1:0] EXPECTED = '0,
  parameter int                        SETTLE   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_idx,
  output logic            first_err_vld
);

  localparam int              CW          = N_IN + 1;
  localparam int              TW          = $clog2(MAX_SETTLE + 1);
  localparam logic [TW-1:0]   SETTLE_LOAD = TW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_STIM   = {N_IN{1'b1}};

`ifdef TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  tt_state_e       state_r, state_s;
  logic [N_IN-1:0] stim_r, stim_s;
  logic [CW-1:0]   err_count_r, err_count_s;
  logic [N_IN-1:0] first_err_idx_r, first_err_idx_s;
  logic            first_err_vld_r, first_err_vld_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic            pass_r, pass_s;

  logic            mismatch_s;
  logic [CW-1:0]   err_final_s;
  logic            sweep_end_s;
  logic            timer_load_s;
  logic            timer_en_s;
  logic            timer_zero_s;

  tt_settle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load_s),
    .load_val (SETTLE_LOAD),
    .en       (timer_en_s),
    .zero     (timer_zero_s)
  );

  // Sample-point comparison and the error count this sample would produce.
  always_comb begin
    mismatch_s  = dut_out ^ EXPECTED[stim_r];
    err_final_s = mismatch_s ? (err_count_r + CW'(1)) : err_count_r;
    // The sweep ends at the all-ones stimulus, or at the first mismatch
    // when stop-on-fail is built in.
    sweep_end_s = (stim_r == LAST_STIM) || (STOP_ON_FAIL && mismatch_s);
  end

  // Next-state and next-output logic of the sweep controller.
  always_comb begin
    state_s         = state_r;
    stim_s          = stim_r;
    err_count_s     = err_count_r;
    first_err_idx_s = first_err_idx_r;
    first_err_vld_s = first_err_vld_r;
    busy_s          = busy_r;
    done_s          = done_r;
    pass_s          = pass_r;
    timer_load_s    = 1'b0;
    timer_en_s      = 1'b0;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s         = ST_SETTLE;
          stim_s          = '0;
          err_count_s     = '0;
          first_err_vld_s = 1'b0;
          busy_s          = 1'b1;
          done_s          = 1'b0;
          pass_s          = 1'b0;
          timer_load_s    = 1'b1;
        end else begin
          state_s = state_r;
        end
      end

      ST_SETTLE: begin
        if (timer_zero_s) begin
          state_s = ST_SAMPLE;
        end else begin
          timer_en_s = 1'b1;
        end
      end

      ST_SAMPLE: begin
        err_count_s = err_final_s;
        if (mismatch_s && !first_err_vld_r) begin
          first_err_idx_s = stim_r;
          first_err_vld_s = 1'b1;
        end else begin
          first_err_vld_s = first_err_vld_r;
        end

        if (sweep_end_s) begin
          // stim is left at the last sampled value.
          state_s = ST_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (err_final_s == '0);
        end else begin
          state_s      = ST_SETTLE;
          stim_s       = stim_r + N_IN'(1);
          timer_load_s = 1'b1;
        end
      end

      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        pass_s  = 1'b0;
      end
    endcase
  end

  // Controller state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      stim_r          <= '0;
      err_count_r     <= '0;
      first_err_idx_r <= '0;
      first_err_vld_r <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      pass_r          <= 1'b0;
    end else begin
      state_r         <= state_s;
      stim_r          <= stim_s;
      err_count_r     <= err_count_s;
      first_err_idx_r <= first_err_idx_s;
      first_err_vld_r <= first_err_vld_s;
      busy_r          <= busy_s;
      done_r          <= done_s;
      pass_r          <= pass_s;
    end
  end

  assign stim          = stim_r;
  assign err_count     = err_count_r;
  assign first_err_idx = first_err_idx_r;
  assign first_err_vld = first_err_vld_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign pass          = pass_r;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: a 3-input majority setup with a randomly
// faulted DUT (fault_mask bit k flips the DUT output for stim == k) checked
// every cycle against a timing/result model, plus a 2-input XOR instance.
module tb_truth_table_checker;

  localparam int S1 = 3;  // SETTLE + 1 for the main instance
  localparam int NC = 8;  // combinations of the main instance

`ifdef TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] stim;
  logic       dut_out;
  logic       busy, done, pass, first_err_vld;
  logic [3:0] err_count;
  logic [2:0] first_err_idx;
  logic [7:0] fault_mask;

  logic       start2;
  logic [1:0] stim2;
  logic       dut_out2;
  logic       busy2, done2, pass2, vld2;
  logic [2:0] err2;
  logic [1:0] idx2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic maj(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  assign dut_out  = maj(stim) ^ fault_mask[stim];
  assign dut_out2 = stim2[0] ^ stim2[1];

  truth_table_checker #(.N_IN(3), .EXPECTED(8'b1110_1000), .SETTLE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_vld(first_err_vld));

  truth_table_checker #(.N_IN(2), .EXPECTED(4'b0110), .SETTLE(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stim(stim2), .dut_out(dut_out2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_idx(idx2), .first_err_vld(vld2));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the main instance ----------------
  bit         m_active;  // a sweep has been accepted since reset
  int         m_t;       // cycles since the accepting edge (saturates at end)
  logic [7:0] m_mask;    // fault pattern of the current sweep

  function automatic int first_set(input logic [7:0] m);
    for (int i = 0; i < NC; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int sweep_len(input logic [7:0] m);
    if (STOP && (m != 8'd0)) return (first_set(m) + 1) * S1;
    return NC * S1;
  endfunction

  // Mismatches sampled within t cycles: combination i is sampled at (i+1)*S1.
  function automatic int errs_by(input logic [7:0] m, input int t);
    int n = 0;
    for (int i = 0; i < NC; i++) if (m[i] && ((i + 1) * S1 <= t)) n++;
    return n;
  endfunction

  function automatic bit model_busy();
    return m_active && (m_t < sweep_len(m_mask));
  endfunction

  // Model update on every clock edge, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_t      <= 0;
    end else if (start && !model_busy()) begin
      m_active <= 1'b1;
      m_t      <= 0;
      m_mask   <= fault_mask;
    end else if (model_busy()) begin
      m_t <= m_t + 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int t, tl, ee, fs;
    bit de;
    if (!m_active) begin
      chk("idle_stim", stim, 0);   chk("idle_err", err_count, 0);
      chk("idle_vld", first_err_vld, 0); chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);   chk("idle_pass", pass, 0);
    end else begin
      t  = m_t;
      tl = sweep_len(m_mask);
      fs = first_set(m_mask);
      de = (t >= tl);
      ee = errs_by(m_mask, t);
      chk("busy", busy, int'(!de));
      chk("done", done, int'(de));
      chk("stim", stim, de ? ((STOP && fs >= 0) ? fs : NC - 1) : t / S1);
      chk("err_count", err_count, ee);
      chk("first_vld", first_err_vld, int'(ee > 0));
      if (ee > 0) chk("first_idx", first_err_idx, fs);
      chk("pass", pass, int'(de && ee == 0));
    end
  end

  // Start a sweep on the main instance and count cycles to done.
  task automatic run_sweep(input bit poke, output int n);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #1;
    chk("start_done_clr", done, 0);
    chk("start_busy", busy, 1);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); n++; #1;
      start = poke && (n == 5 || n == 10);
    end
    start = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; fault_mask = 8'd0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_stim", stim, 0); chk("rst_done", done, 0); chk("rst_err", err_count, 0);

    // Correct majority DUT, with extra start pulses while busy.
    run_sweep(1'b1, n);
    chk("A_len", n, 24); chk("A_pass", pass, 1);
    chk("A_err", err_count, 0); chk("A_vld", first_err_vld, 0);

    // DUT output forced to 0 (faults exactly where majority is 1); start while done.
    fault_mask = 8'b1110_1000;
    run_sweep(1'b0, n);
    chk("B_pass", pass, 0); chk("B_vld", first_err_vld, 1); chk("B_idx", first_err_idx, 3);
    if (STOP) begin
      chk("B_len", n, 12); chk("B_err", err_count, 1); chk("B_stim", stim, 3);
    end else begin
      chk("B_len", n, 24); chk("B_err", err_count, 4); chk("B_stim", stim, 7);
    end

    // Reset while stim == 5 mid-sweep, then a clean sweep.
    fault_mask = 8'd0;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    n = 0;
    while (stim != 3'd5 && n < 100) begin @(posedge clk); n++; #1; end
    chk("C_reach5", stim, 5);
    #1 rst_n = 1'b0;
    #1;
    chk("C_stim0", stim, 0); chk("C_busy0", busy, 0); chk("C_err0", err_count, 0);
    chk("C_done0", done, 0); chk("C_vld0", first_err_vld, 0); chk("C_pass0", pass, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    run_sweep(1'b0, n);
    chk("C_len", n, 24); chk("C_pass", pass, 1); chk("C_err", err_count, 0);

    // Two-input XOR instance.
    @(posedge clk); #2 start2 = 1'b1;
    @(posedge clk); #2 start2 = 1'b0;
    n = 0;
    while (!done2 && n < 100) begin @(posedge clk); n++; #1; end
    chk("D_len", n, 8); chk("D_pass", pass2, 1); chk("D_err", err2, 0);
    chk("D_vld", vld2, 0); chk("D_stim", stim2, 3);

    // Randomized sweeps, stray starts and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 299) == 0) begin
        start = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
      end else if (!model_busy() && $urandom_range(0, 3) == 0) begin
        fault_mask = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
        start = 1'b1;
      end else begin
        start = ($urandom_range(0, 9) == 0);
      end
    end
    @(posedge clk); #2 start = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
